// File: rtl/spi_sclk_engine_if.sv
// Bus bundle for the SPI SCLK engine: configuration and request inputs,
// clock/select outputs, strobes and a state observation port.
//
// Handshake: start is a request level that is only looked at when the engine
// is idle and not busy; it is accepted on the rising PCLK edge that ends a
// cycle with start=1, enable=1 and nbits!=0. The frame then completes with a
// one-cycle done pulse or, if enable drops, a one-cycle aborted pulse. The
// master may leave start high; a new frame is taken from the cycle after done.
interface spi_sclk_engine_if #(
    parameter int SPPR_W  = 3,
    parameter int SPR_W   = 3,
    parameter int DIV_W   = 12,
    parameter int NBITS_W = 5,
    parameter int DLY_W   = 4
);
    logic               enable;
    logic               start;
    logic               cpol;
    logic               cpha;
    logic [SPPR_W-1:0]  sppr;
    logic [SPR_W-1:0]   spr;
    logic [NBITS_W-1:0] nbits;
    logic [DLY_W-1:0]   lead_dly;
    logic [DLY_W-1:0]   lag_dly;
    logic [DIV_W-1:0]   baud_rate_divisor;
    logic               sclk;
    logic               ss_n;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               sample_stb;
    logic               shift_stb;
    logic               pre_sample;
    logic               pre_shift;
    logic [1:0]         state_dbg;

    modport master (
        output enable, start, cpol, cpha, sppr, spr, nbits, lead_dly, lag_dly,
        input  baud_rate_divisor, sclk, ss_n, busy, done, aborted,
        input  sample_stb, shift_stb, pre_sample, pre_shift, state_dbg
    );

    modport slave (
        input  enable, start, cpol, cpha, sppr, spr, nbits, lead_dly, lag_dly,
        output baud_rate_divisor, sclk, ss_n, busy, done, aborted,
        output sample_stb, shift_stb, pre_sample, pre_shift, state_dbg
    );
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI master SCLK generator: baud divisor from sppr/spr, all four CPOL/CPHA
// modes, framed transfer with SS lead/lag delays, sample/shift strobes and
// one-cycle-early pre-strobes.
module spi_sclk_engine #(
    parameter int SPPR_W  = 3,
    parameter int SPR_W   = 3,
    parameter int DIV_W   = 12,
    parameter int NBITS_W = 5,
    parameter int DLY_W   = 4
) (
    input logic              PCLK,
    input logic              PRESET,
    spi_sclk_engine_if.slave bus
);
    localparam int EW = NBITS_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LEAD = 2'd1, RUN = 2'd2, LAG = 2'd3} state_t;

    state_t             state;
    logic               cpol_q;
    logic               cpha_q;
    logic [DIV_W-1:0]   h_q;
    logic [NBITS_W-1:0] nbits_q;
    logic [DLY_W-1:0]   lead_q;
    logic [DLY_W-1:0]   lag_q;
    logic [DIV_W-1:0]   hc;
    logic [DLY_W-1:0]   dcnt;
    logic [EW-1:0]      ecnt;
    logic               sclk_q;
    logic               ss_n_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic               sample_q;
    logic               shift_q;
    logic               pre_sample_q;
    logic               pre_shift_q;

    logic [SPPR_W-1:0]  sppr_in;
    logic [SPR_W-1:0]   spr_in;
    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   h_m1;
    logic [DIV_W-1:0]   h_m2;
    logic [EW-1:0]      ecnt_nxt;
    logic [EW-1:0]      last_edge;
    logic               wrap;
    logic               pre_pt;
    logic               start_ok;

    // Classify edge k as {sample, shift}; the final trailing edge of a CPHA=0
    // frame has nothing left to shift out.
    function automatic logic [1:0] edge_kind(input logic [EW-1:0] k,
                                             input logic cpha_l,
                                             input logic [EW-1:0] last_k);
        logic [1:0] kind;
        if (k[0])
            kind = cpha_l ? 2'b01 : 2'b10;
        else if (cpha_l)
            kind = 2'b10;
        else if (k == last_k)
            kind = 2'b00;
        else
            kind = 2'b01;
        return kind;
    endfunction

    // Divisor (sppr+1)*2^(spr+1); shift done in two steps so spr+1 never
    // overflows the spr width.
    always_comb begin
        sppr_in   = bus.sppr;
        spr_in    = bus.spr;
        div       = (({{(DIV_W-SPPR_W){1'b0}}, sppr_in} + DIV_W'(1)) << spr_in) << 1;
        h_m1      = h_q - DIV_W'(1);
        h_m2      = h_q - DIV_W'(2);
        wrap      = (hc == h_m1);
        pre_pt    = (hc == h_m2);
        ecnt_nxt  = ecnt + EW'(1);
        last_edge = {nbits_q, 1'b0};
        start_ok  = bus.start && bus.enable && (bus.nbits != '0) && !busy_q;
    end

    // Frame sequencer: hc counts PCLK cycles within a half-period, every wrap is
    // a half-period boundary that advances the lead, edge or lag count.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state        <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            h_q          <= '0;
            nbits_q      <= '0;
            lead_q       <= '0;
            lag_q        <= '0;
            hc           <= '0;
            dcnt         <= '0;
            ecnt         <= '0;
            sclk_q       <= 1'b0;
            ss_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            sample_q     <= 1'b0;
            shift_q      <= 1'b0;
            pre_sample_q <= 1'b0;
            pre_shift_q  <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            sample_q     <= 1'b0;
            shift_q      <= 1'b0;
            pre_sample_q <= 1'b0;
            pre_shift_q  <= 1'b0;
            if (state != IDLE && !bus.enable) begin
                state     <= IDLE;
                ss_n_q    <= 1'b1;
                sclk_q    <= cpol_q;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
                hc        <= '0;
                dcnt      <= '0;
                ecnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sclk_q <= bus.cpol;
                        ss_n_q <= 1'b1;
                        if (start_ok) begin
                            state   <= LEAD;
                            cpol_q  <= bus.cpol;
                            cpha_q  <= bus.cpha;
                            h_q     <= div;
                            nbits_q <= bus.nbits;
                            lead_q  <= bus.lead_dly;
                            lag_q   <= bus.lag_dly;
                            ss_n_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            hc      <= DIV_W'(1);
                            dcnt    <= '0;
                            ecnt    <= '0;
                        end else begin
                            busy_q <= 1'b0;
                        end
                    end
                    LEAD: begin
                        hc <= wrap ? '0 : hc + DIV_W'(1);
                        if (wrap) begin
                            if (dcnt == lead_q) begin
                                state <= RUN;
                                dcnt  <= '0;
                            end else begin
                                dcnt <= dcnt + DLY_W'(1);
                            end
                        end
                    end
                    RUN: begin
                        hc <= wrap ? '0 : hc + DIV_W'(1);
                        if (wrap) begin
                            sclk_q                <= ~sclk_q;
                            ecnt                  <= ecnt_nxt;
                            {sample_q, shift_q}   <= edge_kind(ecnt_nxt, cpha_q, last_edge);
                            if (ecnt_nxt == last_edge)
                                state <= LAG;
                        end else if (pre_pt) begin
                            {pre_sample_q, pre_shift_q} <= edge_kind(ecnt_nxt, cpha_q, last_edge);
                        end
                    end
                    LAG: begin
                        hc <= wrap ? '0 : hc + DIV_W'(1);
                        if (wrap) begin
                            if (dcnt == lag_q) begin
                                state  <= IDLE;
                                ss_n_q <= 1'b1;
                                done_q <= 1'b1;
                                hc     <= '0;
                                dcnt   <= '0;
                                ecnt   <= '0;
                            end else begin
                                dcnt <= dcnt + DLY_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.baud_rate_divisor = div;
    assign bus.sclk              = sclk_q;
    assign bus.ss_n              = ss_n_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.aborted           = aborted_q;
    assign bus.sample_stb        = sample_q;
    assign bus.shift_stb         = shift_q;
    assign bus.pre_sample        = pre_sample_q;
    assign bus.pre_shift         = pre_shift_q;
    assign bus.state_dbg         = state;
endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: reset, divisor, mode sweep, delays,
// abort, ignored starts, mid-frame reset and back-to-back frames.
module tb_spi_sclk_engine;
    localparam int SPPR_W  = 3;
    localparam int SPR_W   = 3;
    localparam int DIV_W   = 12;
    localparam int NBITS_W = 5;
    localparam int DLY_W   = 4;

    logic PCLK = 1'b0;
    logic PRESET;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    int done_at, abort_at, nedges, clash;
    logic ss_first, busy_done, ss_done;
    // events encoded as cycle*8 + kind: 0 edge, 1 sample, 2 shift, 3 pre_sample, 4 pre_shift
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    // clock
    always #5 PCLK = ~PCLK;

    spi_sclk_engine_if #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .DIV_W(DIV_W),
                         .NBITS_W(NBITS_W), .DLY_W(DLY_W)) bus ();

    spi_sclk_engine #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .DIV_W(DIV_W),
                      .NBITS_W(NBITS_W), .DLY_W(DLY_W)) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input int sppr, input int spr,
                           input int nbits, input int lead, input int lag);
        bus.cpol     = cpol;
        bus.cpha     = cpha;
        bus.sppr     = SPPR_W'(sppr);
        bus.spr      = SPR_W'(spr);
        bus.nbits    = NBITS_W'(nbits);
        bus.lead_dly = DLY_W'(lead);
        bus.lag_dly  = DLY_W'(lag);
    endtask

    // Record DUT events relative to t0 until done, aborted or budget.
    task automatic capture(input int t_start, input int budget, input int abort_edge,
                           input int busy_start_at);
        logic prev;
        int rel;
        prev = bus.sclk;
        got_q.delete();
        done_at = -1;
        abort_at = -1;
        nedges = 0;
        clash = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            rel = cyc - t_start;
            if (rel == 1) begin
                bus.start = 1'b0;
                ss_first = bus.ss_n;
            end
            if (busy_start_at > 0 && rel == busy_start_at) begin
                bus.start = 1'b1;
                bus.nbits = NBITS_W'(2);
            end
            if (busy_start_at > 0 && rel == busy_start_at + 1) bus.start = 1'b0;
            if (bus.done && bus.aborted) clash++;
            if (bus.aborted) begin
                abort_at = rel;
                break;
            end
            if (bus.sclk !== prev) begin
                got_q.push_back(32'(rel * 8));
                nedges++;
                if (nedges == abort_edge) bus.enable = 1'b0;
            end
            prev = bus.sclk;
            if (bus.sample_stb) got_q.push_back(32'(rel * 8 + 1));
            if (bus.shift_stb)  got_q.push_back(32'(rel * 8 + 2));
            if (bus.pre_sample) got_q.push_back(32'(rel * 8 + 3));
            if (bus.pre_shift)  got_q.push_back(32'(rel * 8 + 4));
            if (bus.sample_stb && bus.shift_stb) clash++;
            if (bus.done) begin
                done_at = rel;
                busy_done = bus.busy;
                ss_done = bus.ss_n;
                break;
            end
        end
    endtask

    // Expected event list from the edge timing rule, compared to the capture.
    task automatic verify(input string tag, input logic cpha, input int n, input int h,
                          input int lead, input int lag);
        int l;
        int g;
        int e;
        int kind;
        l = (lead + 1) * h;
        g = (lag + 1) * h;
        exp_q.delete();
        for (int k = 1; k <= 2 * n; k++) begin
            e = l + k * h;
            if (k % 2 == 1) kind = cpha ? 2 : 1;
            else if (cpha) kind = 1;
            else kind = (k == 2 * n) ? 0 : 2;
            exp_q.push_back(32'(e * 8));
            if (kind != 0) begin
                exp_q.push_back(32'(e * 8 + kind));
                exp_q.push_back(32'((e - 1) * 8 + kind + 2));
            end
        end
        exp_q.sort();
        chk({tag, " event count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s evt%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, " done cycle"}, done_at, l + 2 * n * h + g);
        chk({tag, " ss_n low at T+1"}, ss_first, 1'b0);
        chk({tag, " ss_n high at done"}, ss_done, 1'b1);
        chk({tag, " busy at done"}, busy_done, 1'b1);
        chk({tag, " clash"}, clash, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        PRESET = 1'b1;
        bus.enable = 1'b0;
        bus.start = 1'b0;
        set_cfg(1'b0, 1'b0, 0, 0, 8, 0, 0);
        tick();
        tick();
        chk("reset sclk", bus.sclk, 1'b0);
        chk("reset ss_n", bus.ss_n, 1'b1);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset aborted", bus.aborted, 1'b0);
        chk("reset strobes", {bus.sample_stb, bus.shift_stb, bus.pre_sample, bus.pre_shift}, 4'b0);
        chk("reset state", bus.state_dbg, 2'd0);
        PRESET = 1'b0;
        bus.enable = 1'b1;

        // divisor
        set_cfg(1'b0, 1'b0, 7, 7, 8, 0, 0);
        #1 chk("div 7/7", bus.baud_rate_divisor, 12'd2048);
        set_cfg(1'b0, 1'b0, 2, 1, 8, 0, 0);
        #1 chk("div 2/1", bus.baud_rate_divisor, 12'd12);
        set_cfg(1'b0, 1'b0, 0, 0, 8, 0, 0);
        #1 chk("div 0/0", bus.baud_rate_divisor, 12'd2);

        // mode 0, H=2, 8 bits
        tick();
        chk("t1 idle sclk", bus.sclk, 1'b0);
        bus.start = 1'b1;
        t0 = cyc;
        capture(t0, 200, 0, 0);
        verify("t1", 1'b0, 8, 2, 0, 0);

        // back-to-back: start held through done cycle, taken the cycle after
        bus.start = 1'b1;
        tick();
        chk("b2b ss_n after done", bus.ss_n, 1'b1);
        chk("b2b busy after done", bus.busy, 1'b0);
        t0 = cyc;
        capture(t0, 200, 0, 0);
        verify("b2b", 1'b0, 8, 2, 0, 0);

        // mode sweep
        for (int m = 0; m < 4; m++) begin
            set_cfg(m[1], m[0], 0, 0, 4, 0, 0);
            tick();
            chk($sformatf("t2 m%0d idle sclk", m), bus.sclk, m[1]);
            bus.start = 1'b1;
            t0 = cyc;
            capture(t0, 200, 0, 0);
            verify($sformatf("t2 m%0d", m), m[0], 4, 2, 0, 0);
            chk($sformatf("t2 m%0d sclk at done", m), bus.sclk, m[1]);
        end

        // lead/lag delays, H=4, one bit
        set_cfg(1'b0, 1'b0, 1, 0, 1, 3, 1);
        tick();
        bus.start = 1'b1;
        t0 = cyc;
        capture(t0, 200, 0, 0);
        verify("t4", 1'b0, 1, 4, 3, 1);

        // largest divisor
        set_cfg(1'b0, 1'b1, 7, 7, 1, 0, 0);
        tick();
        bus.start = 1'b1;
        t0 = cyc;
        capture(t0, 9000, 0, 0);
        verify("t3 h2048", 1'b1, 1, 2048, 0, 0);

        // abort after edge 5 of 16
        set_cfg(1'b1, 1'b1, 0, 0, 8, 0, 0);
        tick();
        bus.start = 1'b1;
        t0 = cyc;
        capture(t0, 200, 5, 0);
        chk("t5 abort cycle", abort_at, 13);
        chk("t5 edges before abort", nedges, 5);
        chk("t5 no done", done_at, -1);
        chk("t5 ss_n", bus.ss_n, 1'b1);
        chk("t5 sclk", bus.sclk, 1'b1);
        chk("t5 busy", bus.busy, 1'b0);
        chk("t5 done", bus.done, 1'b0);
        chk("t5 strobes", {bus.sample_stb, bus.shift_stb, bus.pre_sample, bus.pre_shift}, 4'b0);
        bus.enable = 1'b1;
        tick();
        chk("t5 aborted one cycle", bus.aborted, 1'b0);
        bus.start = 1'b1;
        t0 = cyc;
        capture(t0, 200, 0, 0);
        verify("t5 restart", 1'b1, 8, 2, 0, 0);

        // nbits=0 start ignored
        set_cfg(1'b0, 1'b0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        tick();
        tick();
        chk("t6 nbits0 ss_n", bus.ss_n, 1'b1);
        chk("t6 nbits0 busy", bus.busy, 1'b0);
        chk("t6 nbits0 state", bus.state_dbg, 2'd0);
        bus.start = 1'b0;

        // start while busy ignored, frame keeps latched config
        set_cfg(1'b0, 1'b1, 0, 0, 4, 0, 0);
        tick();
        bus.start = 1'b1;
        t0 = cyc;
        capture(t0, 200, 0, 7);
        verify("t6 busy start", 1'b1, 4, 2, 0, 0);

        // reset mid-RUN
        set_cfg(1'b1, 1'b0, 0, 0, 8, 0, 0);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("t6 mid-run state", bus.state_dbg, 2'd2);
        PRESET = 1'b1;
        tick();
        chk("t6 preset sclk", bus.sclk, 1'b0);
        chk("t6 preset ss_n", bus.ss_n, 1'b1);
        chk("t6 preset busy", bus.busy, 1'b0);
        chk("t6 preset done/aborted", {bus.done, bus.aborted}, 2'b0);
        chk("t6 preset strobes", {bus.sample_stb, bus.shift_stb, bus.pre_sample, bus.pre_shift}, 4'b0);
        chk("t6 preset state", bus.state_dbg, 2'd0);
        PRESET = 1'b0;
        tick();
        chk("t6 idle tracks cpol", bus.sclk, 1'b1);
        chk("t6 no pulse after preset", {bus.done, bus.aborted}, 2'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
